// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a small byte FIFO.
// One frame per buffered byte; the line stays high for CLEANUP + IDLE between frames.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 384,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_L,
  input  logic                          i_Tx_DV,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int              PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [12:0]     BIT_LAST   = 13'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_t;

  state_t           state;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_index;
  logic [2:0]       next_index;
  logic [12:0]      clk_count;
  logic             wr_en;
  logic             rd_en;

  // Ready is derived from the registered count, so a pop on the same edge
  // never frees a slot for a coincident write.
  always_comb begin
    o_Tx_Ready   = (count != FULL_COUNT) && i_Rst_L;
    wr_en        = i_Tx_DV && o_Tx_Ready;
    rd_en        = (state == IDLE) && (count != '0);
    next_index   = bit_index + 3'd1;
    o_Fifo_Count = count;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en) begin
      fifo_mem[wr_ptr] <= i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      clk_count   <= '0;
      bit_index   <= '0;
      shift_reg   <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          o_Tx_Done   <= 1'b0;
          if (rd_en) begin
            shift_reg   <= fifo_mem[rd_ptr];
            clk_count   <= '0;
            bit_index   <= '0;
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
            state       <= START;
          end
        end

        START: begin
          if (clk_count == BIT_LAST) begin
            clk_count   <= '0;
            o_Tx_Serial <= shift_reg[0];
            state       <= DATA;
          end else begin
            clk_count <= clk_count + 13'd1;
          end
        end

        DATA: begin
          if (clk_count == BIT_LAST) begin
            clk_count <= '0;
            if (bit_index == 3'd7) begin
              o_Tx_Serial <= 1'b1;
              state       <= STOP;
            end else begin
              bit_index   <= next_index;
              o_Tx_Serial <= shift_reg[next_index];
            end
          end else begin
            clk_count <= clk_count + 13'd1;
          end
        end

        STOP: begin
          if (clk_count == BIT_LAST) begin
            clk_count   <= '0;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b1;
            state       <= CLEANUP;
          end else begin
            clk_count <= clk_count + 13'd1;
          end
        end

        CLEANUP: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Done   <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          o_Tx_Done   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 384, clocks per serial bit (31250 baud MIDI at 12 MHz); legal range 4..8191.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer entries; power of two, 2..16.
REQ-003 SHALL have port i_Clock  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_Rst_L  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_Tx_DV  input  1  write strobe, byte offered this cycle.
REQ-006 SHALL have port i_Tx_Byte  input  8  byte to transmit, sampled when i_Tx_DV=1.
REQ-007 SHALL have port o_Tx_Ready  output  1  FIFO can accept a write this cycle.
REQ-008 SHALL have port o_Tx_Serial  output  1  serial line, idle high, registered.
REQ-009 SHALL have port o_Tx_Active  output  1  frame in progress (start through stop bit).
REQ-010 SHALL have port o_Tx_Done  output  1  one-cycle pulse at end of each frame.
REQ-011 SHALL have port o_Fifo_Count  output  $clog2(FIFO_DEPTH)+1  bytes buffered, not counting the byte being shifted.

Function
REQ-012 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity; each bit held exactly CLKS_PER_BIT cycles.
REQ-013 A write SHALL be accepted iff i_Tx_DV=1 and o_Tx_Ready=1 at a rising edge; writes with o_Tx_Ready=0 SHALL be silently dropped, FIFO unchanged.
REQ-014 o_Tx_Ready SHALL equal (o_Fifo_Count != FIFO_DEPTH) AND i_Rst_L; combinational from registered count.
REQ-015 FIFO SHALL be first-in first-out; read/write pointers wrap modulo FIFO_DEPTH.
REQ-016 State machine states: IDLE, START, DATA, STOP, CLEANUP.
REQ-017 IDLE: o_Tx_Serial=1, o_Tx_Active=0; if count>0, pop head into shift register, clear bit counter and clock counter, go to START.
REQ-018 START: o_Tx_Serial=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-019 DATA: o_Tx_Serial=shift register bit[index], index 0..7, each for CLKS_PER_BIT cycles; after index 7 go to STOP.
REQ-020 STOP: o_Tx_Serial=1 for CLKS_PER_BIT cycles, then go to CLEANUP.
REQ-021 CLEANUP: o_Tx_Serial=1, o_Tx_Done=1 for this single cycle, o_Tx_Active=0; go to IDLE next edge.
REQ-022 o_Tx_Active SHALL be 1 exactly during START, DATA, STOP (10*CLKS_PER_BIT cycles per frame).
REQ-023 Latency: byte written at edge E0 into empty FIFO with block in IDLE SHALL pop at E1; o_Tx_Serial low from E1.
REQ-024 Back-to-back: with FIFO non-empty, inter-frame line-high time beyond stop bit SHALL be exactly 2 cycles (CLEANUP + IDLE).
REQ-025 Simultaneous accepted write and pop SHALL leave o_Fifo_Count unchanged; write of the incoming byte SHALL not be lost.
REQ-026 When full, a write coincident with a pop SHALL be rejected (ready reflects pre-edge count).
REQ-027 Shift-register byte SHALL be immune to FIFO writes during a frame.
REQ-028 Clock counter SHALL be 13 bits; no bit width overflow for legal CLKS_PER_BIT.

Reset
REQ-029 While i_Rst_L=0 at an edge: state IDLE, counters 0, FIFO pointers and count 0, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0.
REQ-030 Reset mid-frame SHALL abort the frame: o_Tx_Serial=1 from that edge, in-flight and buffered bytes discarded, no o_Tx_Done pulse.
REQ-031 Writes presented while i_Rst_L=0 SHALL be ignored (o_Tx_Ready=0).
REQ-032 First edge after i_Rst_L returns high SHALL behave as IDLE with empty FIFO.

Verification (bench CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-033 Single byte 0x90 written idle -> line low at E1, bits 0,0,0,0,1,0,0,1 each 4 cycles, stop high, o_Tx_Done pulse once at cycle E1+40, o_Tx_Active high 40 cycles.
REQ-034 Write 0x90,0x3C,0x64 on consecutive cycles -> three frames in order, each 40 cycles, 2 high cycles between stop bit end and next start.
REQ-035 Six consecutive writes 0x01..0x06 while first frame active -> 0x01 shifting, 0x02..0x05 buffered, count=4, ready=0, 0x06 dropped; line carries 0x01..0x05 only.
REQ-036 Assert i_Rst_L=0 one cycle during DATA bit 3 with 2 bytes buffered -> line high next edge, count=0, no Done; subsequent write 0xF8 transmits cleanly.
REQ-037 FIFO full, pop edge (IDLE) coincident with i_Tx_DV=1 -> write rejected, count goes 4->3; at count 2, coincident write+pop -> count stays 2, byte order preserved.
